// File: rtl/fmdsp_slice_mac_if.sv
// Operation request / result bus of the FMDSP slice MAC.
// The master issues operations and observes results; the slave is the MAC.
interface fmdsp_slice_mac_if #(
  parameter int N     = 16,
  parameter int M     = 16,
  parameter int ACC_W = 40
);

  logic                    start;
  logic                    ready;
  logic                    busy;
  logic [1:0]              mode;
  logic                    mac;
  logic                    clr;
  logic signed [N-1:0]     aa;
  logic signed [M-1:0]     bb;
  logic signed [ACC_W-1:0] cc;
  logic signed [ACC_W-1:0] out;
  logic                    valid;
  logic                    ovf;

  modport master (
    output start, mode, mac, clr, aa, bb, cc,
    input  ready, busy, out, valid, ovf
  );

  modport slave (
    input  start, mode, mac, clr, aa, bb, cc,
    output ready, busy, out, valid, ovf
  );

endinterface

// File: rtl/fmdsp_slice_mac.sv
// Iterative signed multiply-accumulate: aa is multiplied by B one W-bit slice
// per cycle, the partials are summed, and a final saturating add either
// accumulates into out or adds the external addend cc.
module fmdsp_slice_mac #(
  parameter int N     = 16,
  parameter int M     = 16,
  parameter int W     = 4,
  parameter int ACC_W = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  fmdsp_slice_mac_if.slave  bus
);

  localparam int P1 = M / (2 * W);
  localparam int P2 = M / W;
  localparam int KW = $clog2(P2 + 1);
  localparam int SW = $clog2(M) + 1;
  localparam int PW = N + W + 1;
  localparam int XW = N + M;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic signed [N-1:0]     aa_r;
  logic signed [M-1:0]     b_r;
  logic [1:0]              mode_r;
  logic                    mac_r;
  logic signed [ACC_W-1:0] cc_r;
  logic [KW-1:0]           k;
  logic signed [XW-1:0]    work;
  logic signed [ACC_W-1:0] out_r;
  logic                    valid_r;
  logic                    ovf_r;

  logic                    accept;
  logic                    do_pass;
  logic                    do_fin;
  logic                    busy;
  logic [KW-1:0]           p_last;
  logic                    last;
  logic signed [M-1:0]     b_sel;
  logic [SW-1:0]           shamt;
  logic [W-1:0]            slice_raw;
  logic signed [PW-1:0]    aa_x;
  logic signed [PW-1:0]    sl_x;
  logic signed [PW-1:0]    prod;
  logic signed [XW-1:0]    pp_sh;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W:0]   sum;
  logic                    sat;
  logic signed [ACC_W-1:0] fin_val;

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: one CALC cycle per slice, then a single FIN cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CALC;
      CALC:    if (last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded controls; busy/ready come from the state register only.
  always_comb begin
    accept  = (state == IDLE) && bus.start;
    do_pass = (state == CALC);
    do_fin  = (state == FIN);
    busy    = (state != IDLE);
  end

  // Index of the final (sign-carrying) slice for the captured mode.
  always_comb begin
    case (mode_r)
      2'd0:    p_last = '0;
      2'd1:    p_last = KW'(P1 - 1);
      default: p_last = KW'(P2 - 1);
    endcase
    last = (k == p_last);
  end

  // Truncate bb to the requested precision and sign-extend it to M bits.
  always_comb begin
    case (bus.mode)
      2'd0:    b_sel = {{(M - W){bus.bb[W-1]}}, bus.bb[W-1:0]};
      2'd1:    b_sel = {{(M / 2){bus.bb[M/2-1]}}, bus.bb[M/2-1:0]};
      default: b_sel = bus.bb;
    endcase
  end

  // Partial product of the current slice, aligned to its bit position.
  always_comb begin
    shamt     = SW'(int'(k) * W);
    slice_raw = W'(b_r >> shamt);
    sl_x      = last ? {{N{slice_raw[W-1]}}, slice_raw[W-1], slice_raw}
                     : {{N{1'b0}}, 1'b0, slice_raw};
    aa_x      = {{(W + 1){aa_r[N-1]}}, aa_r};
    prod      = aa_x * sl_x;
    pp_sh     = {{(XW - PW){prod[PW-1]}}, prod} << shamt;
  end

  // Final add at one guard bit, with saturation on signed overflow.
  always_comb begin
    if (mac_r) begin
      base = bus.clr ? '0 : out_r;
    end else begin
      base = cc_r;
    end
    sum = {{(ACC_W + 1 - XW){work[XW-1]}}, work} + {base[ACC_W-1], base};
    sat = (sum[ACC_W] != sum[ACC_W-1]);
    if (!sat) begin
      fin_val = sum[ACC_W-1:0];
    end else if (sum[ACC_W]) begin
      fin_val = {1'b1, {(ACC_W - 1){1'b0}}};
    end else begin
      fin_val = {1'b0, {(ACC_W - 1){1'b1}}};
    end
  end

  // Datapath: capture at accept, accumulate partials, write result in FIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aa_r    <= '0;
      b_r     <= '0;
      mode_r  <= '0;
      mac_r   <= 1'b0;
      cc_r    <= '0;
      k       <= '0;
      work    <= '0;
      out_r   <= '0;
      valid_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (accept) begin
        aa_r   <= bus.aa;
        b_r    <= b_sel;
        mode_r <= bus.mode;
        mac_r  <= bus.mac;
        cc_r   <= bus.cc;
        k      <= '0;
        work   <= '0;
      end
      if (do_pass) begin
        work <= work + pp_sh;
        k    <= k + KW'(1);
      end
      if (do_fin) begin
        out_r   <= fin_val;
        ovf_r   <= (ovf_r & ~bus.clr) | sat;
        valid_r <= 1'b1;
      end else if (bus.clr) begin
        out_r <= '0;
        ovf_r <= 1'b0;
      end
    end
  end

  assign bus.busy  = busy;
  assign bus.ready = ~busy;
  assign bus.out   = out_r;
  assign bus.valid = valid_r;
  assign bus.ovf   = ovf_r;

endmodule

// File: tb/tb_fmdsp_slice_mac.sv
// Directed bench for fmdsp_slice_mac with N=M=16, W=4, ACC_W=40: a vector
// table of single operations plus hand-written accumulate, saturation and
// mid-operation reset sequences.
module tb_fmdsp_slice_mac;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   valid_pulses;

  fmdsp_slice_mac_if #(.N(16), .M(16), .ACC_W(40)) bus ();

  fmdsp_slice_mac #(.N(16), .M(16), .W(4), .ACC_W(40)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  mode;
    logic        mac;
    logic [15:0] aa;
    logic [15:0] bb;
    longint      cc;
    longint      exp_out;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count every valid pulse the unit produces.
  always @(posedge clk) begin
    if (bus.valid) valid_pulses++;
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Issue one operation and wait for its valid pulse. Optionally keep
  // pulsing start with junk operands while busy, and raise clr after a
  // given number of post-accept edges (so it lands on the next edge).
  task automatic applyStimulus(input logic [1:0] m, input logic mc,
                               input logic [15:0] a, input logic [15:0] b,
                               input longint c, input bit junk,
                               input int clr_at, output int lat);
    int w;
    lat = -1;
    w = 0;
    @(negedge clk);
    while (!bus.ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    bus.start = 1'b1;
    bus.mode  = m;
    bus.mac   = mc;
    bus.aa    = a;
    bus.bb    = b;
    bus.cc    = 40'(c);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.aa    = 16'h5A5A;
    bus.bb    = 16'h3C3C;
    bus.cc    = 40'sd12345;
    bus.mode  = ~m;
    bus.mac   = ~mc;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.clr   = 1'b0;
      if (bus.valid) begin
        lat = cyc;
        break;
      end
      if (cyc == clr_at) bus.clr = 1'b1;
      if (junk && bus.busy) bus.start = 1'b1;
    end
    bus.start = 1'b0;
    bus.clr   = 1'b0;
  endtask

  task automatic doOp(input string name, input logic [1:0] m, input logic mc,
                      input logic [15:0] a, input logic [15:0] b, input longint c,
                      input bit junk, input int clr_at,
                      input longint exp_out, input int exp_lat);
    int lat;
    applyStimulus(m, mc, a, b, c, junk, clr_at, lat);
    checkOutput({name, " latency"}, longint'(lat), longint'(exp_lat));
    if (lat > 0) checkOutput({name, " out"}, longint'(bus.out), exp_out);
  endtask

  task automatic clearPulse(input string name);
    @(negedge clk);
    bus.clr = 1'b1;
    @(posedge clk);
    #1;
    bus.clr = 1'b0;
    checkOutput({name, " out"}, longint'(bus.out), 64'sd0);
    checkOutput({name, " ovf"}, longint'(bus.ovf), 64'sd0);
  endtask

  initial begin
    int     snap;
    longint exp_acc;
    longint sat_max;

    n_checks     = 0;
    n_fail       = 0;
    valid_pulses = 0;
    sat_max      = 64'sd549755813887;

    vecs[0] = '{2'd2, 1'b0, 16'hFFFD, 16'h7FFF, 64'sd5,     -64'sd98296,      5};
    vecs[1] = '{2'd0, 1'b0, 16'h0064, 16'hABCF, 64'sd0,     -64'sd100,        2};
    vecs[2] = '{2'd0, 1'b0, 16'h0064, 16'h000F, 64'sd0,     -64'sd100,        2};
    vecs[3] = '{2'd1, 1'b0, 16'h8000, 16'h1280, 64'sd0,      64'sd4194304,    3};
    vecs[4] = '{2'd3, 1'b0, 16'h04D2, 16'hFFFE, -64'sd1000, -64'sd3468,       5};
    vecs[5] = '{2'd1, 1'b0, 16'hFFF9, 16'hFF35, 64'sd100,   -64'sd271,        3};
    vecs[6] = '{2'd0, 1'b0, 16'hFFFB, 16'h1237, 64'sd0,     -64'sd35,         2};
    vecs[7] = '{2'd2, 1'b0, 16'h7FFF, 16'h8000, 64'sd0,     -64'sd1073709056, 5};
    vecs[8] = '{2'd2, 1'b0, 16'h8000, 16'h8000, -64'sd1,     64'sd1073741823, 5};
    vecs[9] = '{2'd0, 1'b0, 16'h8000, 16'hFFF8, 64'sd0,      64'sd262144,     2};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.mode  = 2'd0;
    bus.mac   = 1'b0;
    bus.clr   = 1'b0;
    bus.aa    = '0;
    bus.bb    = '0;
    bus.cc    = '0;

    #23;
    checkOutput("reset out",   longint'(bus.out),   64'sd0);
    checkOutput("reset valid", longint'(bus.valid), 64'sd0);
    checkOutput("reset ovf",   longint'(bus.ovf),   64'sd0);
    checkOutput("reset busy",  longint'(bus.busy),  64'sd0);
    checkOutput("reset ready", longint'(bus.ready), 64'sd1);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] vector table");
    for (int i = 0; i < 10; i++) begin
      doOp($sformatf("vec%0d", i), vecs[i].mode, vecs[i].mac, vecs[i].aa,
           vecs[i].bb, vecs[i].cc, 1'b0, 0, vecs[i].exp_out, vecs[i].exp_lat);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d single pulse", i), longint'(bus.valid), 64'sd0);
      checkOutput($sformatf("vec%0d ready", i), longint'(bus.ready), 64'sd1);
    end

    $display("[TB] accumulate with ignored starts");
    clearPulse("acc clr");
    snap = valid_pulses;
    for (int i = 1; i <= 4; i++) begin
      doOp($sformatf("acc%0d", i), 2'd2, 1'b1, 16'd1000, 16'd1000, 64'sd0,
           1'b1, 0, longint'(i) * 64'sd1000000, 5);
    end
    @(posedge clk);
    #1;
    checkOutput("acc pulse count", longint'(valid_pulses - snap), 64'sd4);

    $display("[TB] clr in FIN of last accumulate");
    clearPulse("acc2 clr");
    for (int i = 1; i <= 3; i++) begin
      doOp($sformatf("acc2_%0d", i), 2'd2, 1'b1, 16'd1000, 16'd1000, 64'sd0,
           1'b0, 0, longint'(i) * 64'sd1000000, 5);
    end
    doOp("acc2_4 clr in FIN", 2'd2, 1'b1, 16'd1000, 16'd1000, 64'sd0,
         1'b0, 4, 64'sd1000000, 5);
    checkOutput("acc2_4 ovf", longint'(bus.ovf), 64'sd0);

    $display("[TB] saturation");
    clearPulse("sat clr");
    for (int i = 1; i <= 513; i++) begin
      exp_acc = longint'(i) * 64'sd1073741824;
      if (exp_acc > sat_max) exp_acc = sat_max;
      doOp($sformatf("sat%0d", i), 2'd2, 1'b1, 16'h8000, 16'h8000, 64'sd0,
           1'b0, 0, exp_acc, 5);
      if (i == 511) checkOutput("sat511 ovf", longint'(bus.ovf), 64'sd0);
      if (i == 512) checkOutput("sat512 ovf", longint'(bus.ovf), 64'sd1);
      if (i == 513) checkOutput("sat513 ovf", longint'(bus.ovf), 64'sd1);
    end
    clearPulse("sat final clr");

    $display("[TB] reset during CALC");
    doOp("pre-reset", 2'd2, 1'b0, 16'd3, 16'd3, 64'sd0, 1'b0, 0, 64'sd9, 5);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = 2'd2;
    bus.mac   = 1'b1;
    bus.aa    = 16'd77;
    bus.bb    = 16'h1234;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("mid-op busy", longint'(bus.busy), 64'sd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid-reset out",   longint'(bus.out),   64'sd0);
    checkOutput("mid-reset valid", longint'(bus.valid), 64'sd0);
    checkOutput("mid-reset busy",  longint'(bus.busy),  64'sd0);
    checkOutput("mid-reset ready", longint'(bus.ready), 64'sd1);
    checkOutput("mid-reset ovf",   longint'(bus.ovf),   64'sd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    doOp("post-reset", 2'd2, 1'b0, 16'd7, 16'hFFF7, 64'sd0, 1'b0, 0, -64'sd63, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL global timeout: simulation did not complete, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/fmdsp_slice_mac.md
# fmdsp_slice_mac

Parametrised iterative multiply-accumulate unit for the FMDSP datapath. It computes a signed product by iterating a narrow N×(W+1) multiplier over W-bit slices of B. The number of passes, and so the latency, is set by a per-operation precision mode. Results are either added to an external addend or accumulated in a saturating ACC_W-bit register. This is the successor to the fixed 3-mode DSP core: slice width, accumulator width and precision are generic, and it adds a ready/valid handshake, saturation and an overflow flag.

## Interface
- N, 16: width of operand aa, signed.
- M, 16: width of operand bb, signed; must be divisible by 2W.
- W, 4: slice width of B per pass.
- ACC_W, 40: accumulator/result width; must be ≥ N+M+1.
- Clock and reset (already decided): one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  operation request; accepted when start && ready at a rising edge.
- ready  out  1  equals ~busy; high means the unit can accept an operation.
- busy  out  1  operation in flight.
- mode  in  2  precision: 0 = B is W bits, 1 = B is M/2 bits, 2 or 3 = B is M bits.
- mac  in  1  1: out += product; 0: out = product + cc.
- clr  in  1  synchronous clear of out and ovf.
- aa  in  N  signed multiplicand.
- bb  in  M  signed multiplier; only the low bits selected by mode are used.
- cc  in  ACC_W  signed addend, used when mac=0.
- out  out  ACC_W  registered signed result/accumulator; reset 0.
- valid  out  1  one-cycle pulse when out is updated by an operation; reset 0.
- ovf  out  1  sticky saturation flag; reset 0.

## Operation
- Number of passes P per mode: mode0 → 1; mode1 → M/(2W); mode2 and mode3 → M/W.
- Capture at accept: aa, mode, mac and cc are registered. bb is truncated to the mode width B_w (W, M/2 or M) and sign-extended from bit B_w−1. Inputs are not sampled at any other time.
- Slices:
  - Slice k = bits [kW+W−1 : kW] of the truncated B.
  - Slices 0..P−2 are zero-extended to W+1 bits.
  - Slice P−1 is sign-extended to W+1 bits.
  - The partial product for pass k is aa × slice_k, shifted left by kW.
  - Partials are summed into an N+M-bit signed working register that is cleared at accept.
- FSM:
  - IDLE → CALC on accept, with pass counter k=0.
  - CALC: one pass per cycle, k increments; CALC → FIN after the pass k=P−1.
  - FIN → IDLE, performing the final add.
- Final add:
  - The base is out when mac=1, or cc when mac=0.
  - The working sum is sign-extended to ACC_W+1 bits and added to the base at ACC_W+1 bits.
  - On overflow the result saturates to 2^(ACC_W−1)−1 or −2^(ACC_W−1), and ovf is set.
  - out is written and valid pulses for one cycle.
- ovf stays set until clr or reset; a saturated write never clears it.
- start while busy is ignored: no queueing and no effect on the operation in flight.
- clr outside FIN: out ← 0 and ovf ← 0 at the next edge; an operation in flight is not aborted.
- clr in FIN at the same edge: the accumulate base is taken as 0, out ← product (+cc if mac=0), and ovf is cleared and then set only if this add saturates.
- Reset (any state, including mid-CALC): FSM → IDLE; out, ovf, valid, busy, k and the working register → 0; ready=1. A partial operation is discarded.

## Timing
- Accept at edge E0. Passes are registered at edges E1..EP. FIN writes out and raises valid at edge E(P+1).
- Latency is P+1 cycles. With N=M=16, W=4: mode0 = 2, mode1 = 3, mode2 = 5.
- busy is high from E0+ until the edge E(P+1); ready is high in the cycle valid is high. A back-to-back start is accepted at E(P+2), giving throughput of one operation per P+2 cycles.
- valid is high for exactly one cycle per accepted operation; out holds its value between operations.
- No combinational path from inputs to out, valid or ovf. ready and busy are derived only from registered state.

## Test plan
All scenarios use N=M=16, W=4, ACC_W=40.
- mode2, mac=0, aa=0xFFFD (−3), bb=0x7FFF, cc=5 → out=−98296, valid exactly 5 cycles after accept, single pulse.
- mode0, aa=100, bb=0xABCF (low slice 0xF = −1) → out=−100 after 2 cycles. bb=0x000F gives the identical result, proving the upper bits are ignored.
- mode1, aa=0x8000, bb=0x1280 (low byte 0x80 = −128) → out=4194304 after 3 cycles.
- Accumulate:
  - clr, then 4 ops of mode2, mac=1, aa=bb=1000 → out=4000000.
  - start pulses while busy are ignored: exactly 4 valid pulses.
  - clr asserted in the FIN cycle of the 4th op → out=1000000.
- Saturation: 512 back-to-back ops of mode2, mac=1, aa=bb=0x8000 (each product 2^30).
  - The 512th op → out=0x7F_FFFF_FFFF, ovf=1.
  - A further op keeps out saturated and ovf=1.
  - clr → out=0, ovf=0.
- Reset mid-operation: assert rst_n=0 during CALC pass 2 of a mode2 op → out=0, valid=0, busy=0, ready=1 immediately. After release, mode2 aa=7, bb=−9, mac=0, cc=0 → out=−63 after 5 cycles.
